// File: rtl/pcie_dma_req_arb.sv
// Packet-atomic round-robin arbiter in front of the PCIe DMA TLP engine.
// An in-order ID FIFO routes each response packet back to its requester.
module pcie_dma_req_arb #(
  parameter int NREQ        = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*73-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_dma_valid,
  output logic [72:0]       o_dma_data,
  input  logic              i_dma_ready,
  input  logic              i_resp_valid,
  input  logic [72:0]       i_resp_data,
  output logic              o_resp_ready,
  output logic [NREQ-1:0]   o_resp_valid,
  output logic [72:0]       o_resp_data,
  input  logic [NREQ-1:0]   i_resp_ready,
  output logic              o_busy,
  output logic [4:0]        o_outstanding
);

  localparam int PW = $clog2(OUTSTANDING);

  typedef enum logic {
    IDLE,
    XFER
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [1:0]     rr_last_q, rr_last_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [1:0]     fifo_q [OUTSTANDING];

  logic           pick_valid;
  logic [1:0]     pick;
  logic [1:0]     head;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           req_done;

  assign fifo_empty = (cnt_q == 5'd0);
  assign head       = fifo_q[rd_ptr_q];

  // First valid requester after rr_last, wrapping within NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick       = 2'd0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pick_valid && i_req_valid[k] &&
            k == (int'(rr_last_q) + i) % NREQ) begin
          pick_valid = 1'b1;
          pick       = 2'(k);
        end
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_dma_valid = 1'b0;
    o_dma_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (state_q == XFER && gnt_q == 2'(k)) begin
        o_dma_valid    = i_req_valid[k];
        o_dma_data     = i_req_data[73*k +: 73];
        o_req_ready[k] = i_dma_ready;
      end
    end
  end

  always_comb begin
    o_resp_valid = '0;
    o_resp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!fifo_empty && head == 2'(k)) begin
        o_resp_valid[k] = i_resp_valid;
        o_resp_ready    = i_resp_ready[k];
      end
    end
  end

  assign o_resp_data   = i_resp_data;
  assign o_outstanding = cnt_q;
  assign o_busy        = (state_q == XFER) || !fifo_empty;

  assign push = (state_q == IDLE) && pick_valid &&
                (cnt_q < 5'(OUTSTANDING));
  assign pop  = i_resp_valid && o_resp_ready && i_resp_data[72];
  assign req_done = o_dma_valid && i_dma_ready && o_dma_data[72];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (push) begin
          gnt_d   = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        if (req_done) begin
          rr_last_d = gnt_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'd0;
      rr_last_q <= 2'(NREQ - 1);
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= pick;
  end

endmodule

// File: doc/pcie_dma_req_arb.md
# pcie_dma_req_arb

Packet-atomic round-robin arbiter that shares the single PCIe DMA TLP engine between up to four requester streams and routes each completion stream back to its originator. Sits between the requester FIFOs (each carrying 73-bit last/strob/data words) and the DMA engine's request/response FIFO ports. Arbitration only happens at packet boundaries. An in-order ID FIFO ties each response packet to the requester that issued the matching request packet.

## Interface
- NREQ, 2, number of requesters (2..4)
- OUTSTANDING, 4, max request packets granted but not yet answered (power of 2, 2..16)
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_req_valid  in  NREQ  requester word valid
- i_req_data  in  NREQ*73  packed words; requester k at [73k+72:73k]; word = {last[72], strob[71:64], data[63:0]}
- o_req_ready  out  NREQ  requester word accepted
- o_dma_valid  out  1  word to DMA engine valid
- o_dma_data  out  73  word to DMA engine
- i_dma_ready  in  1  DMA engine accepts word
- i_resp_valid  in  1  DMA response word valid
- i_resp_data  in  73  DMA response word, same layout
- o_resp_ready  out  1  response word accepted
- o_resp_valid  out  NREQ  response valid toward requester k
- o_resp_data  out  73  response word, broadcast to all requesters
- i_resp_ready  in  NREQ  requester k accepts response
- o_busy  out  1  in XFER state or ID FIFO non-empty
- o_outstanding  out  5  ID FIFO occupancy

## Operation
- Request FSM states: IDLE, XFER. Registers: gnt (2 bits), rr_last (2 bits), ID FIFO (OUTSTANDING × 2 bits, wr/rd pointers, count).
- IDLE: all o_req_ready=0 and o_dma_valid=0. If count<OUTSTANDING and any i_req_valid is high, select the first valid requester searching from (rr_last+1) mod NREQ upward with wrap. Latch gnt, push gnt into the ID FIFO, go to XFER. If count==OUTSTANDING, stay in IDLE.
- XFER: combinational passthrough. o_dma_valid=i_req_valid[gnt], o_dma_data=word[gnt], o_req_ready[gnt]=i_dma_ready; other readies are 0.
- On a handshake with last=1 in XFER: rr_last<=gnt, go to IDLE. Non-granted requesters never see ready mid-packet.
- Response routing when the ID FIFO is non-empty:
  - head = FIFO head ID.
  - o_resp_valid[head]=i_resp_valid; all other o_resp_valid=0.
  - o_resp_ready=i_resp_ready[head].
  - o_resp_data=i_resp_data.
- On a response handshake with last=1, pop the ID FIFO.
- ID FIFO empty: o_resp_ready=0 and all o_resp_valid=0. An unsolicited response stalls; it is never dropped.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo OUTSTANDING.
- Requester indices ≥NREQ are never granted.
- Data and strobe words pass through unmodified. The block never inspects TLP headers.

## Timing
- Reset values: state=IDLE, rr_last=NREQ-1 (requester 0 wins first), gnt=0, FIFO empty, count=0.
- Reset output values: o_req_ready=0, o_dma_valid=0, o_resp_ready=0, o_resp_valid=0, o_busy=0, o_outstanding=0. o_dma_data and o_resp_data carry no valid data while their valid is low.
- Grant latency: a request valid seen in IDLE at cycle N gives o_dma_valid at N+1 (first word).
- Packet spacing: one IDLE bubble cycle between consecutive packets. A 1-word packet costs 2 cycles, an L-word packet L+1 cycles at full DMA ready.
- Ready/valid paths are combinational, zero added latency in both directions. The DMA engine's own registering breaks loops.
- o_outstanding reflects the push in the cycle after the grant.
- o_outstanding reflects the pop in the cycle after the last-beat handshake.
- Reset asserted mid-packet or mid-response: return to IDLE next edge and discard FIFO contents. Any partial packet is abandoned; the DMA engine is reset by the same i_rst.

## Test plan
- Single requester 0, 3-word write packet, i_dma_ready=1: grant at cycle 1, words on o_dma_data cycles 1–3, IDLE at 4. Then a 1-word response routes only to o_resp_valid[0], and o_outstanding goes 1→0.
- Both requesters continuously valid with 2-word packets, NREQ=2: grant order 0,1,0,1. No interleaving of words within a packet, and 3 cycles per packet.
- i_dma_ready toggling 1,0,1,0 mid-packet on requester 1: o_req_ready[1] mirrors it, no word is lost or duplicated, and requester 0 is held off until requester 1's last beat.
- OUTSTANDING=4 with no responses: four 1-word packets are granted and then arbitration stalls with o_outstanding=4. One response last-beat frees a slot, and the next grant comes 1 cycle after the pop.
- Response ordering with grants 1,0,1: three response packets are delivered to requesters 1,0,1 in order. Holding i_resp_ready[1]=0 stalls o_resp_ready with no loss.
- Unsolicited response with an empty FIFO holds o_resp_ready=0. Asserting i_rst during a 4-word packet gives all outputs at reset values next cycle and o_outstanding=0.
